// File: rtl/mist_console_pkg.sv
// Shared constants for the console receive path.
package mist_console_pkg;

    localparam int CONSOLE_DATA_W          = 8;
    localparam int CONSOLE_FIFO_DEPTH_LOG2 = 4;
    localparam logic [7:0] OVF_CNT_MAX     = 8'hFF;

endpackage

// File: rtl/mist_console_fifo_ram.sv
// Simple dual-port byte storage: synchronous write, asynchronous read so the
// head entry falls through to the reader without a clock of latency.
module mist_console_fifo_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mist_console_rx_fifo.sv
// Console receive FIFO: one byte per rising edge of in_strobe, FWFT read side.
// Build option MIST_CONSOLE_RX_OVFCNT_EN adds a saturating dropped-byte counter.
module mist_console_rx_fifo
    import mist_console_pkg::*;
#(
    parameter int DEPTH_LOG2 = CONSOLE_FIFO_DEPTH_LOG2
) (
    input  logic                      clk,
    input  logic                      n_reset,
    input  logic [CONSOLE_DATA_W-1:0] in_data,
    input  logic                      in_strobe,
    input  logic                      rd_ack,
    output logic [CONSOLE_DATA_W-1:0] rd_data,
    output logic                      empty,
    output logic                      full,
    output logic [DEPTH_LOG2:0]       count,
    output logic                      overflow,
    input  logic                      ovf_clr,
    output logic [7:0]                ovf_count
);

    localparam int PTR_W = DEPTH_LOG2 + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             strobe_d;
    logic             push;
    logic             pop;
    logic             wr_en;
    logic             drop;

    // strobe_d resets high so a strobe already asserted at reset release is ignored
    assign push  = in_strobe & ~strobe_d;
    assign pop   = rd_ack & ~empty;
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            strobe_d <= 1'b1;
            overflow <= 1'b0;
        end else begin
            strobe_d <= in_strobe;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef MIST_CONSOLE_RX_OVFCNT_EN
    logic [7:0] ovf_cnt_q;

    // a drop in the same cycle as a clear leaves the count at one
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            ovf_cnt_q <= 8'h00;
        end else if (ovf_clr) begin
            ovf_cnt_q <= drop ? 8'h01 : 8'h00;
        end else if (drop && (ovf_cnt_q != OVF_CNT_MAX)) begin
            ovf_cnt_q <= ovf_cnt_q + 8'h01;
        end
    end

    assign ovf_count = ovf_cnt_q;
`else
    assign ovf_count = 8'h00;
`endif

    mist_console_fifo_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (CONSOLE_DATA_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[DEPTH_LOG2-1:0]),
        .wr_data (in_data),
        .rd_addr (rd_ptr[DEPTH_LOG2-1:0]),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_mist_console_rx_fifo.sv
// Scoreboard bench for mist_console_rx_fifo; the monitor checks every accepted pop
// against the queue of bytes the stimulus expects the FIFO to have stored.
module tb_mist_console_rx_fifo;

    logic       clk = 1'b0;
    logic       n_reset;
    logic [7:0] in_data;
    logic       in_strobe;
    logic       rd_ack;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic       ovf_clr;
    logic [7:0] ovf_count;

`ifdef MIST_CONSOLE_RX_OVFCNT_EN
    localparam int EXP_OVF_ONE = 1;
    localparam int EXP_OVF_SAT = 255;
`else
    localparam int EXP_OVF_ONE = 0;
    localparam int EXP_OVF_SAT = 0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    mist_console_rx_fifo dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .in_data   (in_data),
        .in_strobe (in_strobe),
        .rd_ack    (rd_ack),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .ovf_count (ovf_count)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // monitor: any pop accepted at the coming edge must present the scoreboard head
    always @(negedge clk) begin
        if (n_reset === 1'b1 && rd_ack === 1'b1 && empty === 1'b0) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 1, 0);
            end else begin
                check("pop_data", int'(rd_data), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // strobe high for 'hold' cycles then low one cycle; 'stored' says whether the byte should land
    task automatic push_byte(input logic [7:0] d, input int hold, input bit stored);
        in_data   = d;
        in_strobe = 1'b1;
        if (stored) exp_q.push_back(d);
        repeat (hold) tick();
        in_strobe = 1'b0;
        tick();
    endtask

    task automatic drain(input int n);
        rd_ack = 1'b1;
        repeat (n) tick();
        rd_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_reset   = 1'b0;
        in_data   = 8'h00;
        in_strobe = 1'b1;
        rd_ack    = 1'b0;
        ovf_clr   = 1'b0;
        repeat (3) tick();
        check("reset_empty", int'(empty), 1);
        check("reset_count", int'(count), 0);
        check("reset_full", int'(full), 0);
        check("reset_overflow", int'(overflow), 0);
        check("reset_ovf_count", int'(ovf_count), 0);

        // strobe already high at release: no capture
        n_reset = 1'b1;
        repeat (5) tick();
        check("held_strobe_empty", int'(empty), 1);
        check("held_strobe_count", int'(count), 0);
        in_strobe = 1'b0;
        tick();

        // long strobe yields exactly one byte, visible the cycle after the edge
        in_data   = 8'h41;
        in_strobe = 1'b1;
        exp_q.push_back(8'h41);
        tick();
        check("first_push_count", int'(count), 1);
        check("first_push_data", int'(rd_data), 8'h41);
        repeat (19) tick();
        in_strobe = 1'b0;
        tick();
        check("long_strobe_count", int'(count), 1);
        drain(1);
        check("after_pop_empty", int'(empty), 1);

        // fill, overflow, ordered drain
        for (int i = 0; i < 16; i++) push_byte(8'(i), 1, 1'b1);
        check("fill_full", int'(full), 1);
        check("fill_count", int'(count), 16);
        check("fill_no_ovf", int'(overflow), 0);
        push_byte(8'hAA, 1, 1'b0);
        check("drop_full", int'(full), 1);
        check("drop_count", int'(count), 16);
        check("drop_overflow", int'(overflow), 1);
        check("drop_ovf_count", int'(ovf_count), EXP_OVF_ONE);
        drain(16);
        check("drain_empty", int'(empty), 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("clr_overflow", int'(overflow), 0);
        check("clr_ovf_count", int'(ovf_count), 0);

        // push and pop together while full
        for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i), 1, 1'b1);
        in_data   = 8'h55;
        in_strobe = 1'b1;
        rd_ack    = 1'b1;
        exp_q.push_back(8'h55);
        tick();
        rd_ack    = 1'b0;
        in_strobe = 1'b0;
        tick();
        check("pushpop_count", int'(count), 16);
        check("pushpop_overflow", int'(overflow), 0);
        drain(16);
        check("pushpop_drain_empty", int'(empty), 1);

        // pops on an empty FIFO are ignored
        drain(5);
        check("empty_pop_count", int'(count), 0);
        check("empty_pop_empty", int'(empty), 1);
        push_byte(8'h7E, 1, 1'b1);
        check("after_empty_pop_data", int'(rd_data), 8'h7E);
        check("after_empty_pop_count", int'(count), 1);
        drain(1);

        // clear colliding with a drop: set wins
        for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i), 1, 1'b1);
        push_byte(8'hC1, 1, 1'b0);
        in_data   = 8'hC2;
        in_strobe = 1'b1;
        ovf_clr   = 1'b1;
        tick();
        ovf_clr   = 1'b0;
        in_strobe = 1'b0;
        tick();
        check("clr_vs_drop_overflow", int'(overflow), 1);
        check("clr_vs_drop_ovf_count", int'(ovf_count), EXP_OVF_ONE);
        for (int i = 0; i < 300; i++) push_byte(8'hEE, 1, 1'b0);
        check("sat_ovf_count", int'(ovf_count), EXP_OVF_SAT);
        check("sat_count", int'(count), 16);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("final_clr_ovf_count", int'(ovf_count), 0);
        check("final_clr_overflow", int'(overflow), 0);
        drain(16);
        check("final_empty", int'(empty), 1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
